// File: rtl/bep_frame_sync.sv
// bep_frame_sync: hunts the decoded Manchester bit stream for a sync word,
// then forwards a fixed number of payload bits as single-cycle strobes with
// frame-begin / frame-end / frame-abort status pulses.
// Optional feature macro: BEP_FRAME_CRC_EN (adds a trailing CRC-8 field,
// poly 0x07, init 0x00, MSB first, checked against the payload).
module bep_frame_sync #(
  parameter logic [7:0] SYNC_WORD      = 8'hAB,
  parameter int         SYNC_WIDTH     = 8,
  parameter int         PAYLOAD_BITS   = 64,
  parameter int         TIMEOUT_CYCLES = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       serial_clock,
  input  logic       serial_data,
  output logic       frame_begin,
  output logic       in_frame,
  output logic       bit_valid,
  output logic       bit_data,
  output logic [7:0] bit_count,
  output logic       frame_end,
  output logic       frame_abort,
  output logic       crc_ok
);

  localparam int          IW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0]  ST_HUNT      = 2'd0;
  localparam logic [1:0]  ST_PAYLOAD   = 2'd1;
  localparam logic [1:0]  ST_CRC       = 2'd2;
  localparam logic [7:0]  PAYLOAD_LAST = 8'(PAYLOAD_BITS);
  localparam logic [7:0]  SYNC_FILL    = 8'(SYNC_WIDTH);
  localparam logic [7:0]  SYNC_MASK    = 8'((16'h0001 << SYNC_WIDTH) - 16'h0001);
  localparam logic [IW-1:0] TIMEOUT_LAST = IW'(TIMEOUT_CYCLES);

  logic          serial_clock_q, serial_clock_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    sync_q, sync_d;
  logic [7:0]    fill_q, fill_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [7:0]    bit_count_q, bit_count_d;
  logic          frame_begin_q, frame_begin_d;
  logic          in_frame_q, in_frame_d;
  logic          bit_valid_q, bit_valid_d;
  logic          bit_data_q, bit_data_d;
  logic          frame_end_q, frame_end_d;
  logic          frame_abort_q, frame_abort_d;

  logic          edge_s;
  logic          busy_s;
  logic [7:0]    sync_shift_s;
  logic [7:0]    fill_inc_s;

`ifdef BEP_FRAME_CRC_EN
  logic [7:0]    crc_q, crc_d;
  logic [7:0]    crc_rx_q, crc_rx_d;
  logic [2:0]    crc_cnt_q, crc_cnt_d;
  logic          crc_ok_q, crc_ok_d;
  logic [7:0]    crc_rx_shift_s;

  // One MSB-first CRC-8 step, polynomial x^8 + x^2 + x + 1.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return fb ? ({crc[6:0], 1'b0} ^ 8'h07) : {crc[6:0], 1'b0};
  endfunction
`endif

  // Next-state logic: edge detect, hunt / payload / CRC sequencing and timeout.
  always_comb begin
    serial_clock_d = enable ? serial_clock : serial_clock_q;
    edge_s         = serial_clock & ~serial_clock_q & enable;
    busy_s         = (state_q == ST_PAYLOAD) || (state_q == ST_CRC);
    sync_shift_s   = {sync_q[6:0], serial_data};
    fill_inc_s     = (fill_q == 8'hFF) ? fill_q : (fill_q + 8'd1);

    state_d       = state_q;
    sync_d        = sync_q;
    fill_d        = fill_q;
    idle_d        = idle_q;
    bit_count_d   = bit_count_q;
    bit_data_d    = bit_data_q;
    frame_begin_d = 1'b0;
    bit_valid_d   = 1'b0;
    frame_end_d   = 1'b0;
    frame_abort_d = 1'b0;
`ifdef BEP_FRAME_CRC_EN
    crc_d          = crc_q;
    crc_rx_d       = crc_rx_q;
    crc_cnt_d      = crc_cnt_q;
    crc_ok_d       = crc_ok_q;
    crc_rx_shift_s = {crc_rx_q[6:0], serial_data};
`endif

    case (state_q)
      ST_HUNT: begin
        if (edge_s) begin
          sync_d = sync_shift_s;
          fill_d = fill_inc_s;
          if ((fill_inc_s >= SYNC_FILL) &&
              ((sync_shift_s & SYNC_MASK) == (SYNC_WORD & SYNC_MASK))) begin
            frame_begin_d = 1'b1;
            bit_count_d   = 8'd0;
            state_d       = ST_PAYLOAD;
            sync_d        = 8'd0;
            fill_d        = 8'd0;
`ifdef BEP_FRAME_CRC_EN
            crc_d         = 8'h00;
`endif
          end else begin
            state_d = ST_HUNT;
          end
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_PAYLOAD: begin
        if (edge_s) begin
          bit_valid_d = 1'b1;
          bit_data_d  = serial_data;
          bit_count_d = bit_count_q + 8'd1;
`ifdef BEP_FRAME_CRC_EN
          crc_d       = crc8_step(crc_q, serial_data);
`endif
          if ((bit_count_q + 8'd1) == PAYLOAD_LAST) begin
`ifdef BEP_FRAME_CRC_EN
            state_d   = ST_CRC;
            crc_cnt_d = 3'd0;
`else
            frame_end_d = 1'b1;
            state_d     = ST_HUNT;
`endif
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
`ifdef BEP_FRAME_CRC_EN
      ST_CRC: begin
        if (edge_s) begin
          crc_rx_d  = crc_rx_shift_s;
          crc_cnt_d = crc_cnt_q + 3'd1;
          if (crc_cnt_q == 3'd7) begin
            crc_ok_d    = (crc_rx_shift_s == crc_q);
            frame_end_d = 1'b1;
            state_d     = ST_HUNT;
          end else begin
            state_d = ST_CRC;
          end
        end else begin
          state_d = ST_CRC;
        end
      end
`endif
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    // Idle timeout: counts only while enabled inside a frame with no edge;
    // an edge in the expiry cycle takes priority and clears the count.
    if (busy_s && enable && !edge_s) begin
      if ((idle_q + IW'(1)) == TIMEOUT_LAST) begin
        frame_abort_d = 1'b1;
        state_d       = ST_HUNT;
        idle_d        = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end else if (busy_s && !enable) begin
      idle_d = idle_q;
    end else begin
      idle_d = '0;
    end

    // Any return to HUNT starts the sync search from scratch.
    if (busy_s && (state_d == ST_HUNT)) begin
      sync_d = 8'd0;
      fill_d = 8'd0;
    end else begin
      sync_d = sync_d;
    end

    in_frame_d = (state_d == ST_PAYLOAD) || (state_d == ST_CRC);
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      serial_clock_q <= 1'b0;
      state_q        <= ST_HUNT;
      sync_q         <= 8'd0;
      fill_q         <= 8'd0;
      idle_q         <= '0;
      bit_count_q    <= 8'd0;
      frame_begin_q  <= 1'b0;
      in_frame_q     <= 1'b0;
      bit_valid_q    <= 1'b0;
      bit_data_q     <= 1'b0;
      frame_end_q    <= 1'b0;
      frame_abort_q  <= 1'b0;
    end else begin
      serial_clock_q <= serial_clock_d;
      state_q        <= state_d;
      sync_q         <= sync_d;
      fill_q         <= fill_d;
      idle_q         <= idle_d;
      bit_count_q    <= bit_count_d;
      frame_begin_q  <= frame_begin_d;
      in_frame_q     <= in_frame_d;
      bit_valid_q    <= bit_valid_d;
      bit_data_q     <= bit_data_d;
      frame_end_q    <= frame_end_d;
      frame_abort_q  <= frame_abort_d;
    end
  end

`ifdef BEP_FRAME_CRC_EN
  // CRC accumulator, received-CRC shifter and result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc_q     <= 8'h00;
      crc_rx_q  <= 8'h00;
      crc_cnt_q <= 3'd0;
      crc_ok_q  <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      crc_rx_q  <= crc_rx_d;
      crc_cnt_q <= crc_cnt_d;
      crc_ok_q  <= crc_ok_d;
    end
  end

  assign crc_ok = crc_ok_q;
`else
  assign crc_ok = 1'b1;
`endif

  assign frame_begin = frame_begin_q;
  assign in_frame    = in_frame_q;
  assign bit_valid   = bit_valid_q;
  assign bit_data    = bit_data_q;
  assign bit_count   = bit_count_q;
  assign frame_end   = frame_end_q;
  assign frame_abort = frame_abort_q;

endmodule
